// File: rtl/wb_frame_reader.sv
// wb_frame_reader: Wishbone B3 burst master that streams a DDR2 framebuffer into a FWFT FIFO
// for the VGA pixel path. Contains the FIFO (wb_frame_fifo) and the reader (wb_frame_reader).
// Optional build macro FRAME_READER_STATS_EN adds the underrun_cnt_o statistics output.

// Purpose: first-word-fall-through FIFO with synchronous flush and an occupancy count.
// Latency: a pushed word is visible on pop_dat/pop_vld the cycle after the push.
// Backpressure: pop only when pop_vld & pop_rdy; the writer must respect level (no full guard).
module wb_frame_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  output logic                   pop_vld,
  input  logic                   pop_rdy,
  output logic [WIDTH-1:0]       pop_dat,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;

  assign pop_vld = (level != '0);
  assign pop     = pop_vld & pop_rdy;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents are don't-care until the level says otherwise, so no reset.
  always_ff @(posedge wb_clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush behaves like reset.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_vld) - LW'(pop);
    end
  end
endmodule

// Purpose: read framebuffer words over incrementing Wishbone bursts and queue them for the pixel path.
// Latency: a burst issues one cycle after IDLE qualifies it; each acked beat reaches pix_* a cycle later.
// Backpressure: a burst only issues with BURST_LEN free FIFO entries, so the slave is never stalled by us.
module wb_frame_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h3c000,
  parameter logic [31:0] FRAME_WORDS = 32'h3a980,
  parameter int          BURST_LEN   = 4,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        enable_i,
  input  logic        frame_sync_i,
  output logic [31:0] wbm_adr_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [7:0]  wbm_sel_o,
  input  logic [63:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic [63:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        frame_done_o,
  output logic        err_o
`ifdef FRAME_READER_STATS_EN
  ,
  output logic [15:0] underrun_cnt_o
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_t;

  state_t        state, nxt_state;
  logic [31:0]   word_cnt, nxt_word_cnt;
  logic [31:0]   adr_q, nxt_adr;
  logic [2:0]    cti_q, nxt_cti;
  logic          cyc_q, nxt_cyc;
  logic [BW-1:0] blen, nxt_blen;
  logic [BW-1:0] beats, nxt_beats;
  logic          sync_pend, nxt_sync_pend;
  logic          err_q, nxt_err;

  logic          fifo_push;
  logic          fifo_flush;
  logic          fifo_vld;
  logic [LW-1:0] fifo_level;
  logic [LW-1:0] free_cnt;
  logic          free_ok;
  logic [31:0]   words_left;
  logic [BW-1:0] burst_len_calc;
  logic          frame_done;

  // Bursts are clipped at the frame end so a burst never straddles the wrap.
  assign words_left     = FRAME_WORDS - word_cnt;
  assign burst_len_calc = (words_left < 32'(BURST_LEN)) ? words_left[BW-1:0] : BW'(BURST_LEN);
  // Only checked in IDLE, where no beats are outstanding, so level alone is the reservation.
  assign free_cnt       = LW'(FIFO_DEPTH) - fifo_level;
  assign free_ok        = (free_cnt >= LW'(BURST_LEN));

  // State register and all burst bookkeeping.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      adr_q     <= BASE_ADDR;
      cti_q     <= CTI_CLASSIC;
      cyc_q     <= 1'b0;
      blen      <= '0;
      beats     <= '0;
      sync_pend <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= nxt_state;
      word_cnt  <= nxt_word_cnt;
      adr_q     <= nxt_adr;
      cti_q     <= nxt_cti;
      cyc_q     <= nxt_cyc;
      blen      <= nxt_blen;
      beats     <= nxt_beats;
      sync_pend <= nxt_sync_pend;
      err_q     <= nxt_err;
    end
  end

  // Next-state logic: burst issue, per-beat accounting, error abort and frame sync handling.
  always_comb begin
    nxt_state     = state;
    nxt_word_cnt  = word_cnt;
    nxt_adr       = adr_q;
    nxt_cti       = cti_q;
    nxt_cyc       = cyc_q;
    nxt_blen      = blen;
    nxt_beats     = beats;
    nxt_sync_pend = sync_pend;
    nxt_err       = err_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    frame_done    = 1'b0;

    case (state)
      S_IDLE: begin
        if (frame_sync_i || sync_pend) begin
          // Restart the frame; this cycle is spent flushing, the next may issue.
          nxt_word_cnt  = '0;
          nxt_adr       = BASE_ADDR;
          nxt_sync_pend = 1'b0;
          fifo_flush    = 1'b1;
        end else if (enable_i && free_ok) begin
          nxt_state = S_BURST;
          nxt_blen  = burst_len_calc;
          nxt_beats = '0;
          nxt_adr   = BASE_ADDR + {word_cnt[28:0], 3'b000};
          nxt_cyc   = 1'b1;
          nxt_cti   = (burst_len_calc == BW'(1)) ? CTI_END : CTI_INCR;
        end
      end

      S_BURST: begin
        if (frame_sync_i) nxt_sync_pend = 1'b1;
        if (wbm_err_i) begin
          // Failed word is not consumed; the next burst re-reads it from word_cnt.
          nxt_err   = 1'b1;
          nxt_cyc   = 1'b0;
          nxt_cti   = CTI_CLASSIC;
          nxt_state = S_DRAIN;
        end else if (wbm_ack_i) begin
          fifo_push = 1'b1;
          nxt_beats = beats + BW'(1);
          if (word_cnt == FRAME_WORDS - 32'd1) begin
            nxt_word_cnt = '0;
            nxt_adr      = BASE_ADDR;
            frame_done   = 1'b1;
          end else begin
            nxt_word_cnt = word_cnt + 32'd1;
            nxt_adr      = adr_q + 32'd8;
          end
          if (beats == blen - BW'(2)) nxt_cti = CTI_END;
          // Last beat overrides the end-of-burst marker above.
          if (beats == blen - BW'(1)) begin
            nxt_cyc   = 1'b0;
            nxt_cti   = CTI_CLASSIC;
            nxt_state = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (frame_sync_i) nxt_sync_pend = 1'b1;
        nxt_state = S_IDLE;
      end

      default: nxt_state = S_IDLE;
    endcase
  end

  wb_frame_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .flush    (fifo_flush),
    .push_vld (fifo_push & ~wb_rst),
    .push_dat (wbm_dat_i),
    .pop_vld  (fifo_vld),
    .pop_rdy  (pix_ready_i),
    .pop_dat  (pix_data_o),
    .level    (fifo_level)
  );

  assign wbm_adr_o    = adr_q;
  assign wbm_cti_o    = cti_q;
  assign wbm_bte_o    = 2'b00;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = 1'b0;
  assign wbm_sel_o    = {8{cyc_q}};
  assign pix_valid_o  = fifo_vld;
  assign frame_done_o = frame_done & ~wb_rst;
  assign err_o        = err_q;

`ifdef FRAME_READER_STATS_EN
  logic [15:0] underrun_cnt;

  // Counts cycles the consumer wanted a word while the reader was enabled but had none.
  always_ff @(posedge wb_clk) begin
    if (wb_rst || frame_sync_i) begin
      underrun_cnt <= '0;
    end else if (enable_i && pix_ready_i && !fifo_vld && (underrun_cnt != 16'hffff)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt_o = underrun_cnt;
`endif
endmodule

// File: tb/tb_wb_frame_reader.sv
// Testbench for wb_frame_reader: small frame (10 words), bursts of 4, FIFO of 8,
// with a Wishbone slave model that returns an incrementing data counter.
module tb_wb_frame_reader;
  localparam logic [31:0] BASE = 32'h3c000;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic        enable_i;
  logic        frame_sync_i;
  logic [31:0] wbm_adr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [7:0]  wbm_sel_o;
  logic [63:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [63:0] pix_data_o;
  logic        pix_valid_o;
  logic        pix_ready_i;
  logic        frame_done_o;
  logic        err_o;
`ifdef FRAME_READER_STATS_EN
  logic [15:0] underrun_cnt_o;
`endif

  wb_frame_reader #(
    .BASE_ADDR   (BASE),
    .FRAME_WORDS (32'd10),
    .BURST_LEN   (4),
    .FIFO_DEPTH  (8)
  ) dut (
    .wb_clk         (wb_clk),
    .wb_rst         (wb_rst),
    .enable_i       (enable_i),
    .frame_sync_i   (frame_sync_i),
    .wbm_adr_o      (wbm_adr_o),
    .wbm_cti_o      (wbm_cti_o),
    .wbm_bte_o      (wbm_bte_o),
    .wbm_cyc_o      (wbm_cyc_o),
    .wbm_stb_o      (wbm_stb_o),
    .wbm_we_o       (wbm_we_o),
    .wbm_sel_o      (wbm_sel_o),
    .wbm_dat_i      (wbm_dat_i),
    .wbm_ack_i      (wbm_ack_i),
    .wbm_err_i      (wbm_err_i),
    .pix_data_o     (pix_data_o),
    .pix_valid_o    (pix_valid_o),
    .pix_ready_i    (pix_ready_i),
    .frame_done_o   (frame_done_o),
    .err_o          (err_o)
`ifdef FRAME_READER_STATS_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  always #5 wb_clk = ~wb_clk;

  // Slave model: acks after slv_wait wait states, data is a running beat counter,
  // optional one-shot error on the beat whose counter equals slv_err_at.
  logic        slv_clr = 1'b1;
  logic        slv_stall = 1'b0;
  logic [3:0]  slv_wait = 4'd0;
  logic [31:0] slv_err_at = 32'hffff_ffff;
  logic [31:0] slv_cnt;
  logic [3:0]  slv_wcnt;
  logic        slv_err_done;
  logic        slv_beat;

  assign slv_beat  = wbm_cyc_o && wbm_stb_o && !slv_stall && (slv_wcnt == slv_wait);
  assign wbm_err_i = slv_beat && !slv_err_done && (slv_cnt == slv_err_at);
  assign wbm_ack_i = slv_beat && !wbm_err_i;
  assign wbm_dat_i = {32'h0, slv_cnt};

  always @(posedge wb_clk) begin
    if (slv_clr) begin
      slv_cnt      <= 32'd0;
      slv_wcnt     <= 4'd0;
      slv_err_done <= 1'b0;
    end else begin
      if (wbm_ack_i) slv_cnt <= slv_cnt + 32'd1;
      if (wbm_err_i) slv_err_done <= 1'b1;
      if (!(wbm_cyc_o && wbm_stb_o) || wbm_ack_i || wbm_err_i) slv_wcnt <= 4'd0;
      else if (!slv_stall) slv_wcnt <= slv_wcnt + 4'd1;
    end
  end

  // Overflow watch: an ack arriving while the FIFO is already full.
  int ovf_cnt = 0;
  always @(negedge wb_clk) begin
    if (!wb_rst && wbm_ack_i && (int'(dut.u_fifo.level) == 8)) ovf_cnt <= ovf_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_assert();
    wb_rst       = 1'b1;
    enable_i     = 1'b0;
    frame_sync_i = 1'b0;
    pix_ready_i  = 1'b0;
    slv_clr      = 1'b1;
    slv_stall    = 1'b0;
    slv_wait     = 4'd0;
    slv_err_at   = 32'hffff_ffff;
    @(posedge wb_clk); #1;
    @(posedge wb_clk); #1;
  endtask

  task automatic reset_release();
    wb_rst  = 1'b0;
    slv_clr = 1'b0;
  endtask

  typedef struct {
    bit          en;
    bit          rdy;
    bit          cyc;
    logic [31:0] adr;
    logic [2:0]  cti;
    bit          vld;
    logic [63:0] dat;
    bit          fd;
  } vec_t;

  vec_t        vecs[15];
  int          n_acks, n_bursts, pops, pops_before, gap, rises, unstable, exp_word;
  bit          found, prev_cyc, prev_wait;
  logic [31:0] hold_adr;
  logic [2:0]  hold_cti;
  logic [31:0] ack_adr[4];
  logic [2:0]  ack_cti[4];
  logic [2:0]  exp_cti[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle-by-cycle trace: acks every cycle, consumer always ready.
    // Bursts: 0x3c000 x4, 0x3c020 x4, 0x3c040 x2 (frame end), then back to 0x3c000.
    vecs[0]  = '{1, 1, 0, 32'h0,     3'd0, 0, 64'd0, 0};
    vecs[1]  = '{1, 1, 1, 32'h3c000, 3'd2, 0, 64'd0, 0};
    vecs[2]  = '{1, 1, 1, 32'h3c008, 3'd2, 1, 64'd0, 0};
    vecs[3]  = '{1, 1, 1, 32'h3c010, 3'd2, 1, 64'd1, 0};
    vecs[4]  = '{1, 1, 1, 32'h3c018, 3'd7, 1, 64'd2, 0};
    vecs[5]  = '{1, 1, 0, 32'h0,     3'd0, 1, 64'd3, 0};
    vecs[6]  = '{1, 1, 1, 32'h3c020, 3'd2, 0, 64'd0, 0};
    vecs[7]  = '{1, 1, 1, 32'h3c028, 3'd2, 1, 64'd4, 0};
    vecs[8]  = '{1, 1, 1, 32'h3c030, 3'd2, 1, 64'd5, 0};
    vecs[9]  = '{1, 1, 1, 32'h3c038, 3'd7, 1, 64'd6, 0};
    vecs[10] = '{1, 1, 0, 32'h0,     3'd0, 1, 64'd7, 0};
    vecs[11] = '{1, 1, 1, 32'h3c040, 3'd2, 0, 64'd0, 0};
    vecs[12] = '{1, 1, 1, 32'h3c048, 3'd7, 1, 64'd8, 1};
    vecs[13] = '{1, 1, 0, 32'h0,     3'd0, 1, 64'd9, 0};
    vecs[14] = '{1, 1, 1, 32'h3c000, 3'd2, 0, 64'd0, 0};
    exp_cti[0] = 3'd2; exp_cti[1] = 3'd2; exp_cti[2] = 3'd2; exp_cti[3] = 3'd7;

    // ---- Reset values ----
    reset_assert();
    check("rst_cyc", 64'(wbm_cyc_o), 64'd0);
    check("rst_stb", 64'(wbm_stb_o), 64'd0);
    check("rst_we", 64'(wbm_we_o), 64'd0);
    check("rst_sel", 64'(wbm_sel_o), 64'd0);
    check("rst_cti", 64'(wbm_cti_o), 64'd0);
    check("rst_bte", 64'(wbm_bte_o), 64'd0);
    check("rst_adr", 64'(wbm_adr_o), 64'(BASE));
    check("rst_valid", 64'(pix_valid_o), 64'd0);
    check("rst_fdone", 64'(frame_done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    reset_release();

    // ---- Table-driven trace ----
    for (int i = 0; i < 15; i++) begin
      enable_i    = vecs[i].en;
      pix_ready_i = vecs[i].rdy;
      @(negedge wb_clk);
      check($sformatf("A%0d_cyc", i), 64'(wbm_cyc_o), 64'(vecs[i].cyc));
      check($sformatf("A%0d_sel", i), 64'(wbm_sel_o), vecs[i].cyc ? 64'hff : 64'h0);
      check($sformatf("A%0d_cti", i), 64'(wbm_cti_o), 64'(vecs[i].cti));
      check($sformatf("A%0d_valid", i), 64'(pix_valid_o), 64'(vecs[i].vld));
      check($sformatf("A%0d_fdone", i), 64'(frame_done_o), 64'(vecs[i].fd));
      if (vecs[i].cyc) check($sformatf("A%0d_adr", i), 64'(wbm_adr_o), 64'(vecs[i].adr));
      if (vecs[i].vld) check($sformatf("A%0d_data", i), pix_data_o, vecs[i].dat);
      @(posedge wb_clk); #1;
    end

    // ---- Reset in the middle of a burst ----
    check("midrst_cyc_before", 64'(wbm_cyc_o), 64'd1);
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;
    check("midrst_cyc", 64'(wbm_cyc_o), 64'd0);
    check("midrst_valid", 64'(pix_valid_o), 64'd0);

    // ---- Consumer stalled: FIFO fills after two bursts, then drains in order ----
    reset_assert(); reset_release();
    enable_i = 1'b1; pix_ready_i = 1'b0;
    n_acks = 0; n_bursts = 0; prev_cyc = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge wb_clk);
      if (wbm_ack_i) n_acks++;
      if (wbm_cyc_o && !prev_cyc) n_bursts++;
      prev_cyc = wbm_cyc_o;
      @(posedge wb_clk); #1;
    end
    check("B_acks", 64'(n_acks), 64'd8);
    check("B_bursts", 64'(n_bursts), 64'd2);
    check("B_cyc_idle", 64'(wbm_cyc_o), 64'd0);
    pix_ready_i = 1'b1;
    pops = 0; pops_before = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge wb_clk);
      if (wbm_cyc_o && pops_before < 0) pops_before = pops;
      if (pix_valid_o && pops < 12) begin
        check($sformatf("B_pop%0d", pops), pix_data_o, 64'(pops));
        pops++;
      end
    end
    check("B_pops_total", 64'(pops), 64'd12);
    check("B_pops_before_refill", 64'(pops_before), 64'd5);

    // ---- Bus error on the second beat of the first burst ----
    @(posedge wb_clk); #1;
    reset_assert(); reset_release();
    slv_err_at = 32'd1; enable_i = 1'b1; pix_ready_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge wb_clk);
      if (err_o) begin found = 1'b1; break; end
    end
    check("C_err_seen", 64'(found), 64'd1);
    check("C_cyc_dropped", 64'(wbm_cyc_o), 64'd0);
    check("C_fifo_valid", 64'(pix_valid_o), 64'd1);
    check("C_fifo_head", pix_data_o, 64'd0);
    gap = 0; found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge wb_clk);
      gap++;
      if (wbm_cyc_o) begin found = 1'b1; break; end
    end
    check("C_retry_seen", 64'(found), 64'd1);
    check("C_retry_gap", 64'(gap), 64'd2);
    check("C_retry_adr", 64'(wbm_adr_o), 64'h3c008);
    repeat (10) @(negedge wb_clk);
    check("C_err_sticky", 64'(err_o), 64'd1);
    @(posedge wb_clk); #1;
    pix_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge wb_clk);
      check($sformatf("C_pop%0d_valid", k), 64'(pix_valid_o), 64'd1);
      check($sformatf("C_pop%0d", k), pix_data_o, 64'(k));
    end

    // ---- Frame sync while a burst is in flight (word_cnt = 6) ----
    @(posedge wb_clk); #1;
    reset_assert(); reset_release();
    enable_i = 1'b1; pix_ready_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (wbm_cyc_o && wbm_adr_o == BASE + 32'h30) begin found = 1'b1; break; end
      @(posedge wb_clk); #1;
    end
    check("D_word6_reached", 64'(found), 64'd1);
    frame_sync_i = 1'b1; n_acks = 0; prev_cyc = 1'b1;
    @(negedge wb_clk);
    if (wbm_ack_i) n_acks++;
    @(posedge wb_clk); #1;
    frame_sync_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge wb_clk);
      if (wbm_cyc_o && !prev_cyc) begin found = 1'b1; break; end
      if (wbm_ack_i) n_acks++;
      prev_cyc = wbm_cyc_o;
    end
    check("D_restart_seen", 64'(found), 64'd1);
    check("D_burst_completed", 64'(n_acks), 64'd2);
    check("D_restart_adr", 64'(wbm_adr_o), 64'(BASE));
    check("D_fifo_flushed", 64'(pix_valid_o), 64'd0);

    // ---- enable_i dropped mid-burst, three wait states per beat ----
    @(posedge wb_clk); #1;
    reset_assert(); reset_release();
    slv_wait = 4'd3; pix_ready_i = 1'b1; enable_i = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge wb_clk); #1;
      if (wbm_cyc_o) begin found = 1'b1; break; end
    end
    enable_i = 1'b0;
    check("E_burst_started", 64'(found), 64'd1);
    n_acks = 0; unstable = 0; rises = 0; prev_cyc = 1'b1; prev_wait = 1'b0;
    hold_adr = 32'h0; hold_cti = 3'd0;
    for (int k = 0; k < 60; k++) begin
      @(negedge wb_clk);
      if (wbm_cyc_o && !prev_cyc) rises++;
      if (prev_wait && (wbm_adr_o != hold_adr || wbm_cti_o != hold_cti)) unstable++;
      if (wbm_ack_i) begin
        if (n_acks < 4) begin
          ack_adr[n_acks] = wbm_adr_o;
          ack_cti[n_acks] = wbm_cti_o;
        end
        n_acks++;
      end
      prev_wait = wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
      hold_adr  = wbm_adr_o;
      hold_cti  = wbm_cti_o;
      prev_cyc  = wbm_cyc_o;
    end
    check("E_acks", 64'(n_acks), 64'd4);
    check("E_no_new_cyc", 64'(rises), 64'd0);
    check("E_stable_in_wait", 64'(unstable), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("E_beat%0d_adr", i), 64'(ack_adr[i]), 64'(BASE + 32'(8 * i)));
      check($sformatf("E_beat%0d_cti", i), 64'(ack_cti[i]), 64'(exp_cti[i]));
    end

`ifdef FRAME_READER_STATS_EN
    // ---- Underrun statistics: 20 starved cycles, then cleared by frame sync ----
    @(posedge wb_clk); #1;
    reset_assert(); reset_release();
    slv_stall = 1'b1; pix_ready_i = 1'b1; enable_i = 1'b1;
    repeat (20) begin @(posedge wb_clk); #1; end
    enable_i = 1'b0;
    check("F_underrun", 64'(underrun_cnt_o), 64'd20);
    frame_sync_i = 1'b1;
    @(posedge wb_clk); #1;
    frame_sync_i = 1'b0;
    check("F_underrun_cleared", 64'(underrun_cnt_o), 64'd0);
`endif

    check("no_fifo_overflow", 64'(ovf_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
